// File: rtl/pipe_stage_latch.sv
// Configurable inter-stage pipeline register: instruction, LANES data lanes and a valid bit,
// with stall/flush control, a consecutive-hold counter and saturating stall/bubble counters.
module pipe_stage_latch #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [31:0]            ir_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  output logic [31:0]            ir,
  output logic [LANES*WIDTH-1:0] data,
  output logic                   valid,
  output logic [7:0]             hold_cycles,
  output logic [CNT_W-1:0]       stall_count,
  output logic [CNT_W-1:0]       bubble_count
);

  localparam int unsigned DW     = LANES * WIDTH;
  localparam int unsigned HOLD_W = 8;

  if (LANES == 0) begin : g_bad_lanes
    $error("pipe_stage_latch: LANES must be at least 1");
  end
  if (WIDTH == 0) begin : g_bad_width
    $error("pipe_stage_latch: WIDTH must be at least 1");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("pipe_stage_latch: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_e;

  logic [31:0]       ir_q,     ir_d;
  logic [DW-1:0]     data_q,   data_d;
  logic              valid_q,  valid_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic [CNT_W-1:0]  stall_q,  stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  mode_e             mode;

  logic [HOLD_W-1:0] hold_inc;
  logic [CNT_W-1:0]  stall_inc;
  logic [CNT_W-1:0]  bubble_inc;

  // Saturating increments: counters stick at all-ones.
  assign hold_inc   = (&hold_q)   ? hold_q   : hold_q   + HOLD_W'(1);
  assign stall_inc  = (&stall_q)  ? stall_q  : stall_q  + CNT_W'(1);
  assign bubble_inc = (&bubble_q) ? bubble_q : bubble_q + CNT_W'(1);

  // Per-edge action select; flush outranks stall, reset is handled in the register.
  always_comb begin
    mode = MODE_LOAD;
    if (flush) begin
      mode = MODE_FLUSH;
    end else if (stall) begin
      mode = MODE_HOLD;
    end
  end

  always_comb begin
    ir_d     = ir_q;
    data_d   = data_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    stall_d  = stall_q;
    bubble_d = bubble_q;
    unique case (mode)
      MODE_FLUSH: begin
        ir_d     = NOP;
        data_d   = '0;
        valid_d  = 1'b0;
        hold_d   = '0;
        bubble_d = bubble_inc;
      end
      MODE_HOLD: begin
        hold_d  = hold_inc;
        stall_d = stall_inc;
      end
      default: begin
        ir_d    = ir_in;
        data_d  = data_in;
        valid_d = valid_in;
        hold_d  = '0;
        // An upstream bubble still carries its ir through unchanged.
        if (!valid_in) begin
          bubble_d = bubble_inc;
        end
      end
    endcase
  end

  // Capture on the falling edge to match the neighbouring stage latches.
  always_ff @(negedge clock) begin
    if (reset) begin
      ir_q     <= NOP;
      data_q   <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      ir_q     <= ir_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign ir           = ir_q;
  assign data         = data_q;
  assign valid        = valid_q;
  assign hold_cycles  = hold_q;
  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;

endmodule
